// File: rtl/aes_pkg.sv
// Shared AES constants and types.
//   AES_NR     : number of AES-128 rounds
//   AES_KEY_W  : key / round-key width in bits
//   AES_RCON   : round constants, indexed by round 1..10
//   aes_ks_state_e : reverse key-schedule FSM states
package aes_pkg;

  localparam logic [3:0] AES_NR    = 4'd10;
  localparam int         AES_KEY_W = 128;

  localparam logic [7:0] AES_RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } aes_ks_state_e;

  // Round constant lookup that stays defined (zero) outside 1..10, so the
  // XOR network never sees an out-of-range index while rk_round is 0.
  function automatic logic [7:0] aes_rcon(input logic [3:0] round);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      if (round == 4'(i)) begin
        v = AES_RCON[i];
      end else begin
        v = v;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box.
//   x : input byte
//   y : substituted byte
// Computed as the GF(2^8) multiplicative inverse followed by the AES affine
// transform, rather than a 256-entry table.
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    logic       hi;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ aa;
      end else begin
        acc = acc;
      end
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) begin
        aa = aa ^ 8'h1b;
      end else begin
        aa = aa;
      end
    end
    return acc;
  endfunction

  // Inverse as a^254 = a^(2+4+...+128); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] affine(input logic [7:0] b);
    return b
         ^ {b[6:0], b[7]}
         ^ {b[5:0], b[7:6]}
         ^ {b[4:0], b[7:5]}
         ^ {b[3:0], b[7:4]}
         ^ 8'h63;
  endfunction

  // Substitution datapath.
  always_comb begin
    y = affine(gf_inv(x));
  end

endmodule

// File: rtl/aes_inv_key_sched.sv
// Reverse AES-128 key schedule. Loads the round-10 key and streams round
// keys 10 down to 0 under a valid/ready handshake.
//   clk, rst  : clock, synchronous active-high reset
//   start     : start request, honoured only while idle
//   last_key  : round-10 key, w[40] in [127:96]
//   rk        : current round key (same word order)
//   rk_round  : round index of rk
//   rk_valid  : rk / rk_round valid
//   rk_ready  : consumer takes rk this cycle
//   busy      : stream in progress
//   done      : one-cycle pulse after the round-0 transfer
module aes_inv_key_sched
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] last_key,
  output logic [AES_KEY_W-1:0] rk,
  output logic [3:0]           rk_round,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic                 busy,
  output logic                 done
);

  aes_ks_state_e        state_r;
  logic [AES_KEY_W-1:0] key_r;
  logic [3:0]           round_r;
  logic                 valid_r;
  logic                 busy_r;
  logic                 done_r;

  logic [31:0]          a_s, b_s, c_s, d_s;
  logic [31:0]          ap_s, bp_s, cp_s, dp_s;
  logic [31:0]          rot_s;
  logic [31:0]          sub_s;
  logic [AES_KEY_W-1:0] prev_key_s;

  // Reverse step: undo one forward expansion round from the key register.
  always_comb begin
    a_s   = key_r[127:96];
    b_s   = key_r[95:64];
    c_s   = key_r[63:32];
    d_s   = key_r[31:0];
    dp_s  = d_s ^ c_s;
    cp_s  = c_s ^ b_s;
    bp_s  = b_s ^ a_s;
    rot_s = {dp_s[23:0], dp_s[31:24]};
    ap_s  = a_s ^ sub_s ^ {aes_rcon(round_r), 24'h000000};
    prev_key_s = {ap_s, bp_s, cp_s, dp_s};
  end

  // SubWord on the rotated recovered word d'.
  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .x(rot_s[8*g +: 8]),
      .y(sub_s[8*g +: 8])
    );
  end

  // Control FSM, key register and round counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      key_r   <= '0;
      round_r <= 4'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            key_r   <= last_key;
            round_r <= AES_NR;
            valid_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          done_r <= 1'b0;
          if (valid_r && rk_ready) begin
            if (round_r != 4'd0) begin
              key_r   <= prev_key_s;
              round_r <= round_r - 4'd1;
            end else begin
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rk       = key_r;
  assign rk_round = round_r;
  assign rk_valid = valid_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule
